// File: rtl/decoder_scan_seq.sv
// Scan sequencer stepping a 3-to-8 decoder's {x,y,z} selects with a programmable dwell.
// Optional feature: define SCAN_SKIP_MASK_EN to add skip_mask[7:0] (selects never presented).
module decoder_scan_seq #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_SKIP_MASK_EN
    input  logic [7:0]         skip_mask,
`endif
    output logic               x,
    output logic               y,
    output logic               z,
    output logic               sel_valid,
    output logic               step,
    output logic               busy,
    output logic               done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    state_t             state;
    logic [2:0]         sel;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_eff;
    logic               down_q;
    logic               single_q;
    logic [7:0]         mask_in;
    logic [7:0]         mask_q;

    logic [2:0]         start_sel;
    logic               start_found;
    logic [2:0]         cand_s;
    logic [2:0]         next_sel;
    logic               next_found;
    logic               next_wrap;
    logic [2:0]         cand_n;

`ifdef SCAN_SKIP_MASK_EN
    assign mask_in = skip_mask;
`else
    assign mask_in = 8'h00;
`endif

    assign dwell_eff = (dwell == '0) ? DWELL_ONE : dwell;

    assign x = sel[2];
    assign y = sel[1];
    assign z = sel[0];

    // First non-skipped select in the requested direction, taken from the live mask.
    always_comb begin
        start_sel   = 3'd0;
        start_found = 1'b0;
        cand_s      = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand_s = mode[0] ? 3'(7 - i) : 3'(i);
            if (!start_found && !mask_in[cand_s]) begin
                start_sel   = cand_s;
                start_found = 1'b1;
            end
        end
    end

    // Next non-skipped select; next_wrap marks that the sweep passed the end of the range.
    always_comb begin
        next_sel   = sel;
        next_found = 1'b0;
        next_wrap  = 1'b1;
        cand_n     = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            cand_n = down_q ? (sel - 3'(i)) : (sel + 3'(i));
            if (!next_found && !mask_q[cand_n]) begin
                next_sel   = cand_n;
                next_found = 1'b1;
                next_wrap  = down_q ? (cand_n >= sel) : (cand_n <= sel);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 3'd0;
            cnt       <= '0;
            dwell_q   <= '0;
            down_q    <= 1'b0;
            single_q  <= 1'b0;
            mask_q    <= 8'h00;
            sel_valid <= 1'b0;
            step      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sel       <= 3'd0;
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                    if (start && !stop && start_found) begin
                        state     <= RUN;
                        sel       <= start_sel;
                        sel_valid <= 1'b1;
                        busy      <= 1'b1;
                        step      <= 1'b1;
                        down_q    <= mode[0];
                        single_q  <= mode[1];
                        dwell_q   <= dwell_eff;
                        cnt       <= dwell_eff - DWELL_ONE;
                        mask_q    <= mask_in;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state     <= IDLE;
                        sel       <= 3'd0;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                        cnt       <= '0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - DWELL_ONE;
                    end else if (single_q && next_wrap) begin
                        state     <= IDLE;
                        sel       <= 3'd0;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        sel  <= next_sel;
                        step <= 1'b1;
                        cnt  <= dwell_q - DWELL_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Self-checking bench for decoder_scan_seq: per-cycle scan model plus directed literal checks.
module tb_decoder_scan_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] dwell;
    logic [7:0]  mask;
    logic        x, y, z, sel_valid, step, busy, done;

    int n_cmp;
    int n_err;

    // Model: the scan is an ordered list of selects, each repeated m_d cycles.
    bit m_run;
    bit m_done;
    bit m_single;
    int m_k;
    int m_d;
    int m_n;
    int order[8];

    decoder_scan_seq #(.DWELL_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .dwell     (dwell),
`ifdef SCAN_SKIP_MASK_EN
        .skip_mask (mask),
`endif
        .x         (x),
        .y         (y),
        .z         (z),
        .sel_valid (sel_valid),
        .step      (step),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            m_k    = 0;
        end else begin
            m_done = 1'b0;
            if (m_run) begin
                if (stop) begin
                    m_run = 1'b0;
                end else begin
                    m_k++;
                    if (m_single && m_k == m_n * m_d) begin
                        m_run  = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else if (start && !stop) begin
                m_n = 0;
                for (int v = 0; v < 8; v++) begin
                    int s;
                    s = mode[0] ? 7 - v : v;
`ifdef SCAN_SKIP_MASK_EN
                    if (!mask[s]) begin
`else
                    begin
`endif
                        order[m_n] = s;
                        m_n++;
                    end
                end
                if (m_n > 0) begin
                    m_run    = 1'b1;
                    m_k      = 0;
                    m_d      = (dwell == 16'd0) ? 1 : int'(dwell);
                    m_single = mode[1];
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_v;
        logic [2:0] es;
        if (rst_n) begin
            if (m_run) begin
                es    = 3'(order[(m_k / m_d) % m_n]);
                exp_v = {1'b0, es, 1'b1, ((m_k % m_d) == 0), 1'b1, 1'b0};
            end else begin
                exp_v = {1'b0, 3'b000, 1'b0, 1'b0, 1'b0, m_done};
            end
            check_output("cycle", {1'b0, x, y, z, sel_valid, step, busy, done}, exp_v);
        end
    end

    initial begin
        int vcnt;
        int dcyc;
        int dcnt;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 2'b00;
        dwell = 16'd0;
        mask  = 8'h00;

        #3;
        check_output("reset_state", {1'b0, x, y, z, sel_valid, step, busy, done}, 8'h00);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Reset asserted mid-scan
        mode = 2'b00; dwell = 16'd3; start = 1'b1;
        next_cycle();
        start = 1'b0;
        check_output("rst_c1_start", {x, y, z, step, busy}, 8'b000_1_1);
        repeat (4) next_cycle();
        check_output("rst_c5_sel", {x, y, z, step}, 8'b001_0);
        #2 rst_n = 1'b0;
        #1 check_output("rst_async", {1'b0, x, y, z, sel_valid, step, busy, done}, 8'h00);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        check_output("rst_idle_busy", {7'd0, busy}, 8'd0);

        // Single sweep up, dwell=2
        mode = 2'b10; dwell = 16'd2; start = 1'b1;
        vcnt = 0; dcyc = 0;
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            if (c == 1) start = 1'b0;
            if (sel_valid) vcnt++;
            if (done) dcyc = c;
            if (c == 3) check_output("sweep_c3", {x, y, z, step}, 8'b001_1);
            if (c == 16) check_output("sweep_c16", {x, y, z, step}, 8'b111_0);
            if (c == 17) check_output("sweep_done_sel", {x, y, z, sel_valid}, 8'b000_0);
        end
        check_output("sweep_valid_cnt", 8'(vcnt), 8'd16);
        check_output("sweep_done_cyc", 8'(dcyc), 8'd17);

        // Continuous down, dwell=0, stopped at cycle 10
        mode = 2'b01; dwell = 16'd0; start = 1'b1;
        dcnt = 0;
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            if (done) dcnt++;
            if (c == 1) begin
                start = 1'b0;
                check_output("down_c1", {x, y, z, step}, 8'b111_1);
            end
            if (c == 2) check_output("down_c2", {x, y, z, step}, 8'b110_1);
            if (c == 8) check_output("down_c8", {x, y, z}, 8'b000);
            if (c == 9) check_output("down_wrap", {x, y, z}, 8'b111);
            if (c == 10) stop = 1'b1;
            if (c == 11) begin
                stop = 1'b0;
                check_output("down_stopped", {x, y, z, busy, sel_valid}, 8'd0);
            end
        end
        check_output("down_no_done", 8'(dcnt), 8'd0);

        // start with new mode/dwell during RUN is ignored
        mode = 2'b10; dwell = 16'd4; start = 1'b1;
        dcyc = 0;
        for (int c = 1; c <= 36; c++) begin
            next_cycle();
            if (done) dcyc = c;
            if (c == 1) start = 1'b0;
            if (c == 2) begin
                start = 1'b1; mode = 2'b01; dwell = 16'd1;
            end
            if (c == 3) begin
                start = 1'b0; mode = 2'b00; dwell = 16'd0;
            end
            if (c == 5) check_output("ignore_c5", {x, y, z, step}, 8'b001_1);
        end
        check_output("ignore_done_cyc", 8'(dcyc), 8'd33);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1; mode = 2'b00; dwell = 16'd1;
        next_cycle();
        start = 1'b0; stop = 1'b0;
        check_output("start_stop_idle", {7'd0, busy}, 8'd0);
        next_cycle();

        // Single sweep down, dwell=1
        mode = 2'b11; dwell = 16'd1; start = 1'b1;
        dcyc = 0;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            if (c == 1) begin
                start = 1'b0;
                check_output("sd_c1", {x, y, z, step}, 8'b111_1);
            end
            if (c == 8) check_output("sd_c8", {x, y, z, step}, 8'b000_1);
            if (done) dcyc = c;
        end
        check_output("sd_done_cyc", 8'(dcyc), 8'd9);

`ifdef SCAN_SKIP_MASK_EN
        // Skip even selects, single sweep up
        mask = 8'b0101_0101; mode = 2'b10; dwell = 16'd1; start = 1'b1;
        dcyc = 0;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            if (c == 1) begin
                start = 1'b0;
                check_output("skip_c1", {x, y, z}, 8'b001);
            end
            if (c == 2) check_output("skip_c2", {x, y, z}, 8'b011);
            if (c == 3) check_output("skip_c3", {x, y, z}, 8'b101);
            if (c == 4) check_output("skip_c4", {x, y, z}, 8'b111);
            if (done) dcyc = c;
        end
        check_output("skip_done_cyc", 8'(dcyc), 8'd5);

        // All selects skipped: no activity
        mask = 8'hFF; mode = 2'b10; start = 1'b1;
        dcnt = 0;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            if (c == 1) start = 1'b0;
            if (busy || done || sel_valid) dcnt++;
        end
        check_output("skip_all", 8'(dcnt), 8'd0);
        mask = 8'h00;
`endif

        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
